// File: rtl/instruction_assembler.sv
// ============================================================================
// instruction_assembler
// ----------------------------------------------------------------------------
// Packs decoded MIPS instruction fields back into 32-bit instruction words and
// streams them into instruction memory through an auto-incrementing write
// port. It sits between the boot/test loader front end and the core's
// instruction memory. Both sides use valid/ready handshakes. There is one
// output register stage, so the latency is one cycle and the throughput is
// one word per clock.
//
// Optional feature macro: INST_ASM_ERR_EN
//   When this macro is defined, the block rejects inconsistent bundles: an
//   R-format bundle with op != 0, or an I/J bundle with op == 0. A rejected
//   bundle is consumed but not written, and err pulses for one cycle. When
//   the macro is undefined, the block packs fields as given and has no err
//   port.
//
// Ports
//   clk        in   1       clock
//   rst_n      in   1       synchronous active-low reset
//   start      in   1       pulse: load base_addr and (re)enter RUN
//   base_addr  in   ADDR_W  first write address
//   in_valid   in   1       field bundle valid
//   in_ready   out  1       block can accept a bundle
//   fmt        in   2       0=R, 1=I, 2=J, 3=NOP
//   op/rs/rt/rd/shamt/func/imm/target  in  instruction fields
//   wr_valid   out  1       memory write request
//   wr_ready   in   1       memory accepts write
//   wr_addr    out  ADDR_W  write word address
//   wr_data    out  INST_W  packed instruction word
//   done       out  1       ADDR_LAST written; held until start or reset
//   err        out  1       (INST_ASM_ERR_EN only) pulse on rejected bundle
// ============================================================================
module instruction_assembler #(
    parameter int INST_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int ADDR_LAST = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0] wr_data,
`ifdef INST_ASM_ERR_EN
    output logic              err,
`endif
    output logic              done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDR_LAST);

    // Build the 32-bit MIPS word for the given format. Fields that the
    // format does not use are ignored.
    function automatic logic [31:0] f_pack(
        input logic [1:0]  f_fmt,
        input logic [5:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_func,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] w;
        case (f_fmt)
            FMT_R:   w = {f_op, f_rs, f_rt, f_rd, f_shamt, f_func};
            FMT_I:   w = {f_op, f_rs, f_rt, f_imm};
            FMT_J:   w = {f_op, f_target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [INST_W-1:0] r_wr_data;
    logic              r_wr_valid;
    logic              r_done;
    logic              r_err;

    logic              w_in_ready;
    logic              w_complete;
    logic              w_accept;
    logic              w_bad;
    logic [INST_W-1:0] w_packed;

    assign w_packed   = INST_W'(f_pack(fmt, op, rs, rt, rd, shamt, func, imm, target));
    assign w_complete = r_wr_valid & wr_ready;
    assign w_accept   = in_valid & w_in_ready;

    // Format/opcode consistency check (only present with the error feature)
    always_comb begin
`ifdef INST_ASM_ERR_EN
        if (fmt == FMT_R) begin
            w_bad = (op != 6'd0);
        end else if ((fmt == FMT_I) || (fmt == FMT_J)) begin
            w_bad = (op == 6'd0);
        end else begin
            w_bad = 1'b0;
        end
`else
        w_bad = 1'b0;
`endif
    end

    // Input-side ready: only in RUN, never while start is asserted, and only
    // when the output stage is empty or is draining this cycle. A draining
    // word at the last address ends the run, so the block must not take a
    // new bundle behind it.
    always_comb begin
        w_in_ready = 1'b0;
        if ((r_state == ST_RUN) && !start) begin
            if (!r_wr_valid) begin
                w_in_ready = 1'b1;
            end else if (wr_ready && (r_addr != LAST_ADDR)) begin
                w_in_ready = 1'b1;
            end else begin
                w_in_ready = 1'b0;
            end
        end else begin
            w_in_ready = 1'b0;
        end
    end

    // Control FSM, address counter and the output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= {ADDR_W{1'b0}};
            r_wr_data  <= {INST_W{1'b0}};
            r_wr_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_addr     <= base_addr;
                        r_wr_valid <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        // Restart: drop any in-flight word.
                        r_addr     <= base_addr;
                        r_wr_valid <= 1'b0;
                    end else begin
                        if (w_complete) begin
                            if (r_addr == LAST_ADDR) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end
                        if (w_accept && !w_bad) begin
                            // A new word replaces a completing one back-to-back.
                            r_wr_data  <= w_packed;
                            r_wr_valid <= 1'b1;
                        end else if (w_complete) begin
                            r_wr_valid <= 1'b0;
                        end
                        if (w_accept && w_bad) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_wr_valid <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_addr  <= base_addr;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wr_valid <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_addr;
    assign wr_data  = r_wr_data;
    assign done     = r_done;
`ifdef INST_ASM_ERR_EN
    assign err      = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = r_err;
`endif

endmodule

// File: tb/tb_instruction_assembler.sv
// Self-checking bench for instruction_assembler. A transaction-level model
// keeps a queue of words that were accepted but not yet written. The bench
// checks every DUT output each cycle against that model, and also checks
// fixed known-answer words in the directed scenarios.
module tb_instruction_assembler;

    localparam int ADDR_W    = 10;
    localparam int ADDR_LAST = 1023;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [5:0]        op;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        func;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              done;
`ifdef INST_ASM_ERR_EN
    logic              err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int          q_addr[$];
    logic [31:0] q_data[$];
    bit          m_run  = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;
    int          m_addr = 0;

    instruction_assembler #(.INST_W(32), .ADDR_W(ADDR_W), .ADDR_LAST(ADDR_LAST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func), .imm(imm),
        .target(target), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef INST_ASM_ERR_EN
        .err(err),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_pack();
        case (fmt)
            2'd0: return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) |
                         (32'(rd) << 11) | (32'(shamt) << 6) | 32'(func);
            2'd1: return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            2'd2: return (32'(op) << 26) | 32'(target);
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit ref_bad();
`ifdef INST_ASM_ERR_EN
        return (fmt == 2'd0) ? (op != 6'd0) : ((fmt == 2'd3) ? 1'b0 : (op == 6'd0));
`else
        return 1'b0;
`endif
    endfunction

    // Called at a falling edge. Checks the outputs just before the next
    // rising edge, advances the model, then moves to the following falling edge.
    task automatic step();
        bit exp_rdy;
        bit last;
        #4;
        if (rst_n) begin
            exp_rdy = m_run && !start &&
                      ((q_addr.size() == 0) || (wr_ready && q_addr[0] != ADDR_LAST));
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("wr_valid", 32'(wr_valid), 32'(q_addr.size() > 0));
            chk("done", 32'(done), 32'(m_done));
`ifdef INST_ASM_ERR_EN
            chk("err", 32'(err), 32'(m_err));
`endif
            if (q_addr.size() > 0) begin
                chk("wr_addr", 32'(wr_addr), 32'(q_addr[0]));
                chk("wr_data", wr_data, q_data[0]);
            end
            m_err = 1'b0;
            if (start) begin
                q_addr.delete(); q_data.delete();
                m_addr = int'(base_addr); m_run = 1'b1; m_done = 1'b0;
            end else if (m_run) begin
                if ((q_addr.size() > 0) && wr_ready) begin
                    last = (q_addr[0] == ADDR_LAST);
                    void'(q_addr.pop_front()); void'(q_data.pop_front());
                    if (last) begin
                        m_run = 1'b0; m_done = 1'b1;
                    end
                end
                if (in_valid && exp_rdy) begin
                    if (ref_bad()) begin
                        m_err = 1'b1;
                    end else begin
                        q_addr.push_back(m_addr); q_data.push_back(ref_pack());
                        m_addr++;
                    end
                end
            end
        end else begin
            q_addr.delete(); q_data.delete();
            m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fields(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh; func = fn; imm = im; target = tg;
    endtask

    task automatic do_start(input int b);
        start = 1'b1; base_addr = ADDR_W'(b);
        step();
        start = 1'b0;
    endtask

    logic [31:0] held_data;
    logic [9:0]  held_addr;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; wr_ready = 1'b0;
        set_fields(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        step();   // idle cycle: in_ready/wr_valid/done must be 0

        // 1: R word at base 0
        do_start(0);
        wr_ready = 1'b1; in_valid = 1'b1;
        set_fields(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
        step();
        in_valid = 1'b0;
        chk("t1_data", wr_data, 32'h0022_1820);
        chk("t1_addr", 32'(wr_addr), 32'd0);
        step();

        // 2: I then J back-to-back from base 0
        do_start(0);
        in_valid = 1'b1;
        set_fields(2'd1, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        step();
        chk("t2_i_data", wr_data, 32'h2022_FFFF);
        chk("t2_i_addr", 32'(wr_addr), 32'd0);
        set_fields(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
        step();
        chk("t2_j_data", wr_data, 32'h0810_0000);
        chk("t2_j_addr", 32'(wr_addr), 32'd1);

        // 3: back-pressure for five cycles with a bundle waiting
        wr_ready = 1'b0;
        set_fields(2'd0, 6'd0, 5'd7, 5'd8, 5'd9, 5'd1, 6'h21, 16'd0, 26'd0);
        held_data = wr_data; held_addr = wr_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_data", wr_data, held_data);
            chk("t3_hold_addr", 32'(wr_addr), 32'(held_addr));
        end
        wr_ready = 1'b1;
        step(); step();
        in_valid = 1'b0;
        step();

        // 4: last two addresses, DONE, restart at 5
        do_start(1022);
        in_valid = 1'b1; fmt = 2'd3;
        step(); step();
        in_valid = 1'b0;
        step(); step();
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        do_start(5);
        chk("t4_done_clr", 32'(done), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t4_addr5", 32'(wr_addr), 32'd5);

        // 5: start while a word is stalled
        wr_ready = 1'b0;
        step();
        do_start(100);
        chk("t5_dropped", 32'(wr_valid), 32'd0);
        in_valid = 1'b1;
        set_fields(2'd0, 6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h22, 16'd0, 26'd0);
        step();
        in_valid = 1'b0;
        chk("t5_addr", 32'(wr_addr), 32'd100);
        wr_ready = 1'b1;
        step();

        // 6: R bundle with a non-zero opcode
        in_valid = 1'b1;
        set_fields(2'd0, 6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'd0, 26'd0);
        step();
        in_valid = 1'b0;
`ifdef INST_ASM_ERR_EN
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_nowrite", 32'(wr_valid), 32'd0);
`else
        chk("t6_op", 32'(wr_data[31:26]), 32'h23);
        chk("t6_addr", 32'(wr_addr), 32'd101);
`endif
        step();

        // reset in the middle of a stalled write
        wr_ready = 1'b0; in_valid = 1'b1; fmt = 2'd3;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        chk("mid_rst_valid", 32'(wr_valid), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        step();

        // random traffic with occasional restarts near the top of memory
        do_start(990);
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            set_fields(2'($urandom_range(0, 3)),
                       ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom),
                       5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                       6'($urandom), 16'($urandom), 26'($urandom));
            start = ($urandom_range(0, 79) == 0);
            base_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) :
                        ADDR_W'($urandom_range(990, 1023));
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
